radio_en_sequencer: RTL and testbench

//  Consumes the two-stage-synchronised radio enable / rx-enable levels from the TimingEngine sync stage
//  (radioEnableSynced2, radioRxEnSynced2) and sequences the RF front end: synth warm-up, RX/TX path

---
 rtl/radio_seq_pkg.sv | 18 +
 rtl/seq_down_cnt.sv | 28 ++
 rtl/radio_en_sequencer.sv | 123 ++++++++++++
 tb/tb_radio_en_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/radio_seq_pkg.sv
// Shared types for the RF front-end enable sequencer: state encoding and a
// helper that identifies the states timed by the shared down-counter.
package radio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    RX_ON  = 3'd2,
    TX_ON  = 3'd3,
    TURN   = 3'd4,
    RAMPDN = 3'd5
  } state_t;

  function automatic logic is_timed(input state_t s);
    return (s == WARMUP) || (s == TURN) || (s == RAMPDN);
  endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Load/decrement counter with a zero flag. Saturates at zero and never wraps;
// a load in the same cycle as a decrement wins.
module seq_down_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/radio_en_sequencer.sv
// Sequences synth warm-up, RX/TX path enable, RX<->TX turnaround and ramp-down
// from the synchronised radio enable / rx-select levels.
module radio_en_sequencer
  import radio_seq_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int WARMUP_CYC = 16,
  parameter int TURN_CYC   = 4,
  parameter int RAMPDN_CYC = 8
) (
  input  logic       ck,
  input  logic       arst,
  input  logic       radio_en_s2,
  input  logic       rx_en_s2,
  output logic       synth_en,
  output logic       lna_en,
  output logic       pa_en,
  output logic       busy,
  output logic       ready_pulse,
  output logic       abort_pulse,
  output logic [2:0] state_o
);

  if ((WARMUP_CYC < 1) || (WARMUP_CYC > (1 << CNT_W))) begin : g_bad_warmup
    $error("WARMUP_CYC out of range 1..2**CNT_W");
  end
  if ((TURN_CYC < 1) || (TURN_CYC > (1 << CNT_W))) begin : g_bad_turn
    $error("TURN_CYC out of range 1..2**CNT_W");
  end
  if ((RAMPDN_CYC < 1) || (RAMPDN_CYC > (1 << CNT_W))) begin : g_bad_rampdn
    $error("RAMPDN_CYC out of range 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] WARMUP_LD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] RAMPDN_LD = CNT_W'(RAMPDN_CYC - 1);

  state_t           state;
  state_t           next_state;
  logic             abort;
  logic             entering;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  // Enable drop beats terminal count; the RX/TX target is the rx level seen
  // on the terminal edge, so toggles during TURN are absorbed.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (radio_en_s2) next_state = WARMUP;
      end
      WARMUP, TURN: begin
        if (!radio_en_s2) begin
          next_state = RAMPDN;
          abort      = 1'b1;
        end else if (cnt_zero) begin
          next_state = rx_en_s2 ? RX_ON : TX_ON;
        end
      end
      RX_ON: begin
        if (!radio_en_s2)  next_state = RAMPDN;
        else if (!rx_en_s2) next_state = TURN;
      end
      TX_ON: begin
        if (!radio_en_s2)  next_state = RAMPDN;
        else if (rx_en_s2) next_state = TURN;
      end
      RAMPDN: begin
        if (cnt_zero) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign entering = (next_state != state);
  assign cnt_load = entering && is_timed(next_state);
  assign cnt_dec  = is_timed(state);

  always_comb begin
    cnt_load_val = WARMUP_LD;
    if (next_state == TURN)   cnt_load_val = TURN_LD;
    if (next_state == RAMPDN) cnt_load_val = RAMPDN_LD;
  end

  seq_down_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .ck       (ck),
    .arst     (arst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs are decoded from the next state so they line up with state_o.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      synth_en    <= 1'b0;
      lna_en      <= 1'b0;
      pa_en       <= 1'b0;
      busy        <= 1'b0;
      ready_pulse <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      state       <= next_state;
      synth_en    <= (next_state != IDLE);
      lna_en      <= (next_state == RX_ON);
      pa_en       <= (next_state == TX_ON);
      busy        <= (next_state != IDLE);
      ready_pulse <= entering && ((next_state == RX_ON) || (next_state == TX_ON));
      abort_pulse <= abort;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_radio_en_sequencer.sv
// Directed bench for radio_en_sequencer: expected output vectors are queued
// per cycle and compared against the DUT one time unit after each rising edge.
module tb_radio_en_sequencer;

  logic       ck;
  logic       arst;
  logic       radio_en_s2;
  logic       rx_en_s2;
  logic       synth_en;
  logic       lna_en;
  logic       pa_en;
  logic       busy;
  logic       ready_pulse;
  logic       abort_pulse;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  // {state_o, synth_en, lna_en, pa_en, busy, ready_pulse, abort_pulse}
  logic [8:0] exp_q[$];

  localparam logic [8:0] V_IDLE = 9'b000_0_0_0_0_0_0;
  localparam logic [8:0] V_W    = 9'b001_1_0_0_1_0_0;
  localparam logic [8:0] V_RXR  = 9'b010_1_1_0_1_1_0;
  localparam logic [8:0] V_RX   = 9'b010_1_1_0_1_0_0;
  localparam logic [8:0] V_TXR  = 9'b011_1_0_1_1_1_0;
  localparam logic [8:0] V_TX   = 9'b011_1_0_1_1_0_0;
  localparam logic [8:0] V_TURN = 9'b100_1_0_0_1_0_0;
  localparam logic [8:0] V_RD   = 9'b101_1_0_0_1_0_0;
  localparam logic [8:0] V_RDA  = 9'b101_1_0_0_1_0_1;

  radio_en_sequencer dut (
    .ck          (ck),
    .arst        (arst),
    .radio_en_s2 (radio_en_s2),
    .rx_en_s2    (rx_en_s2),
    .synth_en    (synth_en),
    .lna_en      (lna_en),
    .pa_en       (pa_en),
    .busy        (busy),
    .ready_pulse (ready_pulse),
    .abort_pulse (abort_pulse),
    .state_o     (state_o)
  );

  // clock / reset
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // scoreboard: pop the oldest expectation and compare, plus path exclusivity
  task automatic check(input string tag);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {state_o, synth_en, lna_en, pa_en, busy, ready_pulse, abort_pulse};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: no expectation queued, observed=%b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
    end
    checks++;
    assert (!(lna_en && pa_en) && (synth_en || (!lna_en && !pa_en))) else begin
      failures++;
      $error("FAIL %s_excl: observed lna=%b pa=%b synth=%b expected no overlap, path only with synth",
             tag, lna_en, pa_en, synth_en);
    end
  endtask

  // driver: advance n cycles, queueing and checking the same vector each cycle
  task automatic tick_check(input int n, input logic [8:0] vec, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge ck);
      #1;
      exp_q.push_back(vec);
      check(tag);
    end
  endtask

  initial begin
    int hold;
    arst        = 1'b1;
    radio_en_s2 = 1'b0;
    rx_en_s2    = 1'b0;
    @(posedge ck);
    @(posedge ck);
    #1;
    exp_q.push_back(V_IDLE);
    check("reset_idle");
    arst = 1'b0;
    tick_check(2, V_IDLE, "idle_hold");

    // power-up into RX
    radio_en_s2 = 1'b1;
    rx_en_s2    = 1'b1;
    tick_check(16, V_W, "warmup_rx");
    tick_check(1, V_RXR, "rx_ready");
    hold = $urandom_range(1, 5);
    tick_check(hold, V_RX, "rx_on");

    // RX -> TX turnaround
    rx_en_s2 = 1'b0;
    tick_check(4, V_TURN, "turn_rx_tx");
    tick_check(1, V_TXR, "tx_ready");
    tick_check(1, V_TX, "tx_on");

    // one-cycle rx glitch in TX_ON: full TURN then back to TX
    rx_en_s2 = 1'b1;
    tick_check(1, V_TURN, "glitch_turn_first");
    rx_en_s2 = 1'b0;
    tick_check(3, V_TURN, "glitch_turn");
    tick_check(1, V_TXR, "glitch_tx_ready");
    tick_check(1, V_TX, "glitch_tx_on");

    // drop enable in TX_ON, re-raise during RAMPDN
    radio_en_s2 = 1'b0;
    tick_check(2, V_RD, "rampdn_from_tx");
    radio_en_s2 = 1'b1;
    tick_check(6, V_RD, "rampdn_ignores_en");
    tick_check(1, V_IDLE, "rampdn_done");
    tick_check(1, V_W, "rewarm");

    // abort after 5 warm-up cycles
    tick_check(4, V_W, "warmup_pre_abort");
    radio_en_s2 = 1'b0;
    tick_check(1, V_RDA, "warmup_abort");
    tick_check(7, V_RD, "abort_rampdn");
    tick_check(2, V_IDLE, "abort_idle");

    // abort during TURN
    radio_en_s2 = 1'b1;
    rx_en_s2    = 1'b1;
    tick_check(16, V_W, "warmup_rx2");
    tick_check(1, V_RXR, "rx_ready2");
    rx_en_s2 = 1'b0;
    tick_check(2, V_TURN, "turn_pre_abort");
    radio_en_s2 = 1'b0;
    tick_check(1, V_RDA, "turn_abort");
    tick_check(7, V_RD, "turn_abort_rampdn");
    tick_check(1, V_IDLE, "turn_abort_idle");

    // rx level sampled on the terminal warm-up edge picks the path
    radio_en_s2 = 1'b1;
    rx_en_s2    = 1'b1;
    tick_check(15, V_W, "warmup_tx");
    rx_en_s2 = 1'b0;
    tick_check(1, V_W, "warmup_tx_last");
    tick_check(1, V_TXR, "tx_ready_late_sel");
    tick_check(1, V_TX, "tx_on2");

    // enable drop beats rx change in TX_ON, no abort
    radio_en_s2 = 1'b0;
    rx_en_s2    = 1'b1;
    tick_check(1, V_RD, "tx_drop_priority");
    tick_check(7, V_RD, "tx_drop_rampdn");
    tick_check(1, V_IDLE, "tx_drop_idle");

    // asynchronous reset mid-RX_ON
    radio_en_s2 = 1'b1;
    tick_check(16, V_W, "warmup_rx3");
    tick_check(1, V_RXR, "rx_ready3");
    tick_check(1, V_RX, "rx_on3");
    #3;
    arst = 1'b1;
    #1;
    exp_q.push_back(V_IDLE);
    check("async_reset");
    @(posedge ck);
    #1;
    arst        = 1'b0;
    radio_en_s2 = 1'b0;
    tick_check(2, V_IDLE, "post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
